// File: rtl/ifmap_buffer_pkg.sv
// Shared encodings for the IFMap buffer writer FSM and the read-side buffer status.
package ifmap_buffer_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FILL     = 2'd1;
  localparam logic [1:0] ROW_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = IDLE,
    S_FILL     = FILL,
    S_ROW_DONE = ROW_DONE
  } wr_state_e;

  // Read-side view of the circular buffer, consumed by the writer top.
  localparam logic [1:0] RD_EMPTY   = 2'd0;
  localparam logic [1:0] RD_PARTIAL = 2'd1;
  localparam logic [1:0] RD_FULL    = 2'd2;

  typedef enum logic [1:0] {
    B_EMPTY   = RD_EMPTY,
    B_PARTIAL = RD_PARTIAL,
    B_FULL    = RD_FULL
  } rd_status_e;

endpackage

// File: rtl/ifmap_circular_buffer.sv
// Circular storage with first-word fall-through head; callers only assert
// wr_en when not full and rd_en when not empty.
module ifmap_circular_buffer
  import ifmap_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output rd_status_e               status,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    status = B_PARTIAL;
    if (count == '0)                status = B_EMPTY;
    else if (count == CNT_W'(DEPTH)) status = B_FULL;
  end

  assign rd_data   = mem[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/ifmap_buffer_writer.sv
// Loads one IFMap row of ROW_LEN words into a circular buffer per start request;
// the consumer drains the buffer independently of the writer FSM.
module ifmap_buffer_writer
  import ifmap_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ROW_LEN    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   src_valid,
  input  logic [DATA_WIDTH-1:0]  src_data,
  output logic                   src_ready,
  input  logic                   buffer_read_enable,
  output logic                   buffer_valid,
  output logic [DATA_WIDTH-1:0]  buffer_dout,
  output logic                   buffer_full,
  output logic                   row_done,
  output logic                   busy,
  output logic [1:0]             dbg_state,
  output logic [$clog2(DEPTH):0] dbg_occupancy
);

  localparam logic [7:0] LAST_WORD = 8'(ROW_LEN - 1);

  wr_state_e  state_q, state_d;
  logic [7:0] word_cnt_q;
  rd_status_e buf_status;
  logic       wr_en, rd_en;

  // Handshakes: a write fires on src_valid & src_ready, a pop fires on
  // buffer_read_enable & buffer_valid; both are qualified here before the buffer.
  assign src_ready    = !rst && (state_q == S_FILL) && (buf_status != B_FULL);
  assign buffer_valid = !rst && (buf_status != B_EMPTY);
  assign buffer_full  = !rst && (buf_status == B_FULL);
  assign row_done     = !rst && (state_q == S_ROW_DONE);
  assign busy         = !rst && (state_q != S_IDLE);
  assign wr_en        = src_valid && src_ready;
  assign rd_en        = buffer_read_enable && buffer_valid;
  assign dbg_state    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_FILL;
      S_FILL:     if (wr_en && (word_cnt_q == LAST_WORD)) state_d = S_ROW_DONE;
      S_ROW_DONE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && state_d == S_FILL) word_cnt_q <= '0;
      else if (wr_en)                             word_cnt_q <= word_cnt_q + 8'd1;
    end
  end

  ifmap_circular_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (src_data),
    .rd_en     (rd_en),
    .rd_data   (buffer_dout),
    .status    (buf_status),
    .occupancy (dbg_occupancy)
  );

endmodule

// File: tb/tb_ifmap_buffer_writer.sv
// Directed bench for ifmap_buffer_writer with default parameters.
module tb_ifmap_buffer_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;
  logic        buffer_read_enable;
  logic        buffer_valid;
  logic [15:0] buffer_dout;
  logic        buffer_full;
  logic        row_done;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_occupancy;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  ifmap_buffer_writer dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .src_valid          (src_valid),
    .src_data           (src_data),
    .src_ready          (src_ready),
    .buffer_read_enable (buffer_read_enable),
    .buffer_valid       (buffer_valid),
    .buffer_dout        (buffer_dout),
    .buffer_full        (buffer_full),
    .row_done           (row_done),
    .busy               (busy),
    .dbg_state          (dbg_state),
    .dbg_occupancy      (dbg_occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; exp_rdy is the hand-derived src_ready for this cycle.
  task automatic step(input logic s, input logic v, input logic r,
                      input logic [15:0] d, input logic exp_rdy);
    logic do_wr, do_rd;
    start = s; src_valid = v; buffer_read_enable = r; src_data = d;
    #1;
    check("src_ready", src_ready, exp_rdy);
    check("buffer_valid", buffer_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("buffer_dout", buffer_dout, exp_q[0]);
    check("buffer_full", buffer_full, exp_q.size() == 8);
    do_wr = v && exp_rdy;
    do_rd = r && (exp_q.size() != 0);
    @(posedge clk); #1;
    if (do_rd) void'(exp_q.pop_front());
    if (do_wr) exp_q.push_back(d);
    check("occupancy", dbg_occupancy, exp_q.size());
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0; buffer_read_enable = 1'b0;
    @(posedge clk); #1;
    check("rst_busy_during", busy, 0);
    check("rst_src_ready_during", src_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("rst_busy", busy, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_buffer_valid", buffer_valid, 0);
    check("rst_buffer_full", buffer_full, 0);
    check("rst_row_done", row_done, 0);
    check("rst_state", dbg_state, 0);
    check("rst_occupancy", dbg_occupancy, 0);

    // Row 1: 0x11..0x14, no reads
    step(1, 1, 0, 16'h0011, 0);
    check("row1_state_fill", dbg_state, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0011 + 16'(i), 1);
    check("row1_row_done", row_done, 1);
    check("row1_busy", busy, 1);
    step(0, 0, 0, 16'h0000, 0);
    check("row1_done_clear", row_done, 0);
    check("row1_idle", dbg_state, 0);
    check("row1_busy_clear", busy, 0);

    // Row 2: 0x15..0x18 fills the buffer
    step(1, 1, 0, 16'h0015, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0015 + 16'(i), 1);
    check("row2_row_done", row_done, 1);
    check("row2_full", buffer_full, 1);
    step(1, 0, 0, 16'h0000, 0);
    check("start_in_row_done_ignored", busy, 0);
    step(0, 0, 0, 16'h0000, 0);
    check("start_not_queued", dbg_state, 0);
    step(1, 0, 0, 16'h0000, 0);
    check("fill_while_full", dbg_state, 1);

    // Full: read and write together, write must be blocked
    step(0, 1, 1, 16'h0099, 0);
    check("full_read_occupancy", dbg_occupancy, 7);
    check("full_head_after_pop", buffer_dout, 16'h0012);

    // Drain to occupancy 3, then 10 simultaneous read/write ops across rows
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0000, 1);
    check("occ3", dbg_occupancy, 3);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 16'h0040 + 16'(i), 1);
    check("rw_row_done_a", row_done, 1);
    step(0, 0, 0, 16'h0000, 0);
    step(1, 0, 0, 16'h0000, 0);
    for (int i = 4; i < 8; i++) step(0, 1, 1, 16'h0040 + 16'(i), 1);
    check("rw_row_done_b", row_done, 1);
    step(0, 0, 0, 16'h0000, 0);
    step(1, 0, 0, 16'h0000, 0);
    for (int i = 8; i < 10; i++) step(0, 1, 1, 16'h0040 + 16'(i), 1);
    check("rw_occ_stays_3", dbg_occupancy, 3);
    check("rw_no_row_done", row_done, 0);

    // Reset after 2 of 4 writes in the current row
    start = 1'b0; src_valid = 1'b0; buffer_read_enable = 1'b0;
    rst = 1'b1; #1;
    check("midrst_busy_during", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", buffer_valid, 0);
    check("midrst_row_done", row_done, 0);
    check("midrst_occupancy", dbg_occupancy, 0);
    step(0, 0, 0, 16'h0000, 0);
    check("midrst_no_pulse", row_done, 0);

    // Full row after reset
    step(1, 1, 0, 16'h0021, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0021 + 16'(i), 1);
    check("post_rst_row_done", row_done, 1);
    step(0, 0, 1, 16'h0000, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0000, 0);
    check("drained", buffer_valid, 0);

    // Reads while empty are ignored
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0000, 0);
    check("empty_read_state", dbg_state, 0);
    check("empty_read_occ", dbg_occupancy, 0);

    // First write into empty buffer appears one cycle later
    step(1, 0, 1, 16'h0000, 0);
    step(0, 1, 1, 16'h0031, 1);
    check("no_flow_through_valid", buffer_valid, 1);
    check("no_flow_through_dout", buffer_dout, 16'h0031);
    step(0, 1, 1, 16'h0032, 1);
    step(0, 1, 1, 16'h0033, 1);
    step(0, 1, 1, 16'h0034, 1);
    check("last_row_done", row_done, 1);
    step(0, 0, 1, 16'h0000, 0);
    check("final_empty", buffer_valid, 0);
    check("final_idle", dbg_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifmap_buffer_writer.md
IFMAP_BUFFER_WRITER -- requirements
Module: ifmap_buffer_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one IFMap word.
REQ-002 SHALL have parameter DEPTH, default 8, buffer entries; power of two, >= 2.
REQ-003 SHALL have parameter ROW_LEN, default 4, words per IFMap row; 1..255.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to load one row of ROW_LEN words.
REQ-007 SHALL have port src_valid  input  1  source word available.
REQ-008 SHALL have port src_data  input  DATA_WIDTH  source word.
REQ-009 SHALL have port src_ready  output  1  block accepts src_data this cycle.
REQ-010 SHALL have port buffer_read_enable  input  1  consumer pops head word.
REQ-011 SHALL have port buffer_valid  output  1  buffer non-empty; head word presented.
REQ-012 SHALL have port buffer_dout  output  DATA_WIDTH  head word, first-word fall-through.
REQ-013 SHALL have port buffer_full  output  1  occupancy equals DEPTH.
REQ-014 SHALL have port row_done  output  1  one-cycle pulse after ROW_LEN words are written.
REQ-015 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, ROW_DONE.
REQ-017 IDLE -> FILL when start=1; otherwise remain in IDLE.
REQ-018 FILL -> ROW_DONE on the cycle the ROW_LEN-th write of the row occurs; otherwise remain in FILL.
REQ-019 ROW_DONE -> IDLE unconditionally after one cycle; row_done=1 only in ROW_DONE.
REQ-020 SHALL ignore start outside IDLE; a start in ROW_DONE is not queued.
REQ-021 src_ready SHALL be 1 only in FILL with buffer_full=0; it is combinational from state and occupancy.
REQ-022 A write SHALL occur when src_valid=1 and src_ready=1: store at the write pointer, increment the word counter, and advance the write pointer modulo DEPTH.
REQ-023 buffer_valid SHALL equal (occupancy != 0); buffer_dout SHALL equal the entry at the read pointer with zero-cycle latency.
REQ-024 A read SHALL occur when buffer_read_enable=1 and buffer_valid=1; it advances the read pointer modulo DEPTH.
REQ-025 buffer_read_enable while empty SHALL be ignored, with no pointer or occupancy change.
REQ-026 SHALL support a simultaneous read and write in one cycle: occupancy unchanged, both pointers advance.
REQ-027 When full, a write SHALL be blocked even if a read occurs in the same cycle (no bypass).
REQ-028 When empty, a same-cycle write SHALL NOT be readable until the next cycle (no flow-through).
REQ-029 Occupancy SHALL be $clog2(DEPTH)+1 bits; pointers SHALL be $clog2(DEPTH) bits and wrap naturally.
REQ-030 The word counter SHALL be 8 bits, cleared on entry to FILL, and never exceed ROW_LEN.
REQ-031 Reads SHALL proceed in every FSM state, independent of the write FSM.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, pointers=0, occupancy=0, word counter=0.
REQ-033 Outputs during and after reset: src_ready=0, buffer_valid=0, buffer_full=0, row_done=0, busy=0.
REQ-034 buffer_dout after reset is don't-care; storage contents SHALL NOT be cleared.
REQ-035 Reset mid-FILL SHALL abandon the partial row with no row_done pulse.

Structure
REQ-036 State encoding (2-bit localparams IDLE=0, FILL=1, ROW_DONE=2) SHALL reside in shared package ifmap_buffer_pkg, alongside the read-side controller encodings.
REQ-037 Storage, pointers and occupancy SHALL be one sub-module, ifmap_circular_buffer (DATA_WIDTH, DEPTH); ifmap_buffer_writer SHALL contain the FSM and word counter.
REQ-038 Unreachable state encoding 3 SHALL return to IDLE.

Verification
REQ-039 Use defaults. Apply start and src_valid held at 1 with data 0x11..0x14 and no reads -> src_ready is 1 for 4 cycles, row_done pulses once in the cycle after the 4th write, buffer_valid=1, and the FSM returns to IDLE.
REQ-040 Run two rows with no reads -> buffer_full=1 after 8 writes, and src_ready=0 while start is ignored.
REQ-041 In the full state, assert buffer_read_enable and src_valid together -> the read pops 0x11, the write is blocked, and occupancy is 7.
REQ-042 With occupancy 3, issue a simultaneous read and write for 10 cycles -> occupancy stays 3, both pointers wrap past 7, and data order is preserved.
REQ-043 Assert rst after 2 of 4 writes -> the next cycle shows busy=0, buffer_valid=0 and no row_done; a subsequent start loads a full row correctly.
REQ-044 Assert buffer_read_enable while empty for 3 cycles -> no state change, and the first later write appears at buffer_dout one cycle after it is written.
